// File: rtl/chs_sim_uart_tx.sv
// chs_sim_uart_tx: APB-attached UART transmitter for simulation environments.
// Bytes written to THR are queued in a TX FIFO and serialized as 8N1 frames
// on uart_tx_o with a bit period of DIV+1 clock cycles.
//
// APB handshake: zero wait states, pready_o is always 1. An access phase is
// psel_i & penable_i. Every side effect (push, register write) and the THR
// overflow error happen only in that phase. prdata_o and pslverr_o are
// combinational from the access phase and read 0 outside it.
module chs_sim_uart_tx #(
    parameter int          FifoDepth  = 16,
    parameter logic [15:0] DivDefault = 16'd15
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        psel_i,
    input  logic        penable_i,
    input  logic        pwrite_i,
    input  logic [31:0] paddr_i,
    input  logic [31:0] pwdata_i,
    output logic [31:0] prdata_o,
    output logic        pready_o,
    output logic        pslverr_o,
    output logic        uart_tx_o,
    output logic        irq_o
);

    localparam int AW = $clog2(FifoDepth);
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_e;

    // Register file
    logic [15:0] div_q, div_d;
    logic [1:0]  ctrl_q, ctrl_d;

    // FIFO storage and pointers (extra MSB distinguishes full from empty)
    logic [7:0]    mem_q [FifoDepth];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] count;
    logic          fifo_empty, fifo_full;
    logic          push, pop;

    // Serializer
    state_e      state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [15:0] reload_q, reload_d;
    logic [15:0] baud_q, baud_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic        tx_q, tx_d;
    logic        irq_q, irq_d;

    // APB decode
    logic       access, wr_acc, rd_acc;
    logic [1:0] sel;
    logic       tx_idle;
    logic [7:0] count8;
    logic       unused_bits;

    assign access      = psel_i & penable_i;
    assign wr_acc      = access & pwrite_i;
    assign rd_acc      = access & ~pwrite_i;
    assign sel         = paddr_i[3:2];
    assign unused_bits = ^{paddr_i[31:4], paddr_i[1:0], pwdata_i[31:16]};

    assign count      = wr_ptr_q - rd_ptr_q;
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == PW'(FifoDepth));
    assign tx_idle    = (state_q == S_IDLE) & fifo_empty;
    assign count8     = 8'(count);

    // Full is judged on the registered count, so a same-cycle pop never makes room
    assign push      = wr_acc & (sel == 2'd0) & ~fifo_full;
    assign pslverr_o = wr_acc & (sel == 2'd0) & fifo_full;
    assign pready_o  = 1'b1;

    assign uart_tx_o = tx_q;
    assign irq_o     = irq_q;

    // Read mux, only driven during a read access phase
    always_comb begin
        prdata_o = '0;
        if (rd_acc) begin
            case (sel)
                2'd1:    prdata_o = {16'h0, count8, 5'b0, tx_idle, fifo_full, fifo_empty};
                2'd2:    prdata_o = {16'h0, div_q};
                2'd3:    prdata_o = {30'h0, ctrl_q};
                default: prdata_o = '0;
            endcase
        end
    end

    // DIV and CTRL write logic
    always_comb begin
        div_d  = div_q;
        ctrl_d = ctrl_q;
        if (wr_acc) begin
            if (sel == 2'd2) div_d  = pwdata_i[15:0];
            if (sel == 2'd3) ctrl_d = pwdata_i[1:0];
        end
    end

    // FIFO pointer advance and level interrupt based on next-cycle occupancy
    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
        irq_d    = (wr_ptr_d == rd_ptr_d) & ctrl_d[1];
    end

    // Serializer next-state: IDLE pops and loads, then START/DATA/STOP each DIV+1 cycles
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        reload_d  = reload_q;
        baud_d    = baud_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        pop       = 1'b0;
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (ctrl_q[0] && !fifo_empty) begin
                    pop       = 1'b1;
                    shift_d   = mem_q[rd_ptr_q[AW-1:0]];
                    reload_d  = div_q;
                    baud_d    = div_q;
                    bit_cnt_d = 3'd0;
                    tx_d      = 1'b0;
                    state_d   = S_START;
                end
            end
            S_START: begin
                if (baud_q == 16'd0) begin
                    baud_d    = reload_q;
                    tx_d      = shift_q[0];
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_cnt_d = 3'd0;
                    state_d   = S_DATA;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            S_DATA: begin
                if (baud_q == 16'd0) begin
                    baud_d = reload_q;
                    if (bit_cnt_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        tx_d      = shift_q[0];
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            S_STOP: begin
                if (baud_q == 16'd0) begin
                    tx_d    = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    baud_d = baud_q - 16'd1;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    // FIFO storage; contents are don't-care after reset since pointers clear
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= pwdata_i[7:0];
    end

    // State registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q     <= DivDefault;
            ctrl_q    <= 2'b00;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            state_q   <= S_IDLE;
            shift_q   <= 8'h00;
            reload_q  <= 16'h0;
            baud_q    <= 16'h0;
            bit_cnt_q <= 3'd0;
            tx_q      <= 1'b1;
            irq_q     <= 1'b0;
        end else begin
            div_q     <= div_d;
            ctrl_q    <= ctrl_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            state_q   <= state_d;
            shift_q   <= shift_d;
            reload_q  <= reload_d;
            baud_q    <= baud_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            irq_q     <= irq_d;
        end
    end

endmodule
